// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for inst_sequencer: instruction type bus, FSM state
// encoding, error cause codes and small type-classification helpers.
package inst_sequencer_pkg;

  localparam int TYPE_BUS = 3;

  localparam logic [TYPE_BUS-1:0] INST_N = 3'd0;
  localparam logic [TYPE_BUS-1:0] INST_R = 3'd1;
  localparam logic [TYPE_BUS-1:0] INST_I = 3'd2;
  localparam logic [TYPE_BUS-1:0] INST_S = 3'd3;
  localparam logic [TYPE_BUS-1:0] INST_B = 3'd4;
  localparam logic [TYPE_BUS-1:0] INST_U = 3'd5;
  localparam logic [TYPE_BUS-1:0] INST_J = 3'd6;

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    DECODE     = 3'd2,
    EXECUTE    = 3'd3,
    MEM_REQ    = 3'd4,
    MEM_WAIT   = 3'd5,
    WRITEBACK  = 3'd6,
    ERROR      = 3'd7
  } seq_state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_ITYPE  = 2'd1;
  localparam logic [1:0] ERR_IFU_TO = 2'd2;
  localparam logic [1:0] ERR_LSU_TO = 2'd3;

  // True for every instruction type the sequencer knows how to run.
  function automatic logic itype_legal(input logic [TYPE_BUS-1:0] t);
    return t inside {INST_R, INST_I, INST_S, INST_B, INST_U, INST_J};
  endfunction

  // Stores and branches never write the register file.
  function automatic logic itype_writes_rd(input logic [TYPE_BUS-1:0] t);
    return !(t == INST_S || t == INST_B);
  endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Memory-side bus of inst_sequencer: IFU fetch port and LSU access port.
//
// Handshake rule for both request channels: a request transfers on a clock
// edge where valid and ready are both high. Once valid rises, valid and the
// address hold steady until that edge; ready may toggle freely and is
// ignored while valid is low. A response is a single-cycle valid pulse and
// is only consumed while the sequencer sits in the matching WAIT state.
interface inst_sequencer_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;

  modport master (
    output ifu_req_valid, ifu_addr, lsu_req_valid,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst,
    input  lsu_req_ready, lsu_rsp_valid
  );

  modport slave (
    input  ifu_req_valid, ifu_addr, lsu_req_valid,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst,
    output lsu_req_ready, lsu_rsp_valid
  );
endinterface

// File: rtl/seq_watchdog.sv
// Wait-state watchdog for inst_sequencer. Counts cycles spent in a waiting
// state, restarts on every state change, and flags the cycle in which the
// waiting state has lasted TIMEOUT_CYCLES cycles.
module seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [31:0] cnt;

  // Cycle counter; a state change wins over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt <= '0;
    else if (clear)    cnt <= '0;
    else if (count_en) cnt <= cnt + 32'd1;
  end

  // cnt holds the cycles already spent, so this fires on the last allowed one.
  assign expired = count_en && (cnt == 32'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/inst_sequencer.sv
// inst_sequencer: multi-cycle control FSM of the RV32E NPC. Fetches over the
// IFU port, latches the instruction, steps decode/execute/memory/writeback,
// advances the PC and counts retired instructions.
// Optional feature macro: SEQ_TIMEOUT_EN adds the wait-state watchdog
// (seq_watchdog) that traps stalled IFU/LSU handshakes into ERROR.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  inst_sequencer_if.master    bus,
  input  logic [TYPE_BUS-1:0] itype,
  input  logic                is_load,
  input  logic                is_store,
  input  logic [31:0]         next_pc,
  output logic [31:0]         pc,
  output logic [31:0]         inst_r,
  output logic                exe_en,
  output logic                wb_en,
  output logic [31:0]         retired,
  output logic                seq_err,
  output logic [1:0]          err_code,
  output seq_state_t          dbg_state
);

  seq_state_t state, state_next;
  logic [1:0] err_next;
  // run stays low through reset and the first clock after it, which keeps
  // ifu_req_valid low while rst is high without a rst-to-output path.
  logic       run;
  // Captured at DECODE so wb_en is a pure register decode.
  logic       wb_flag;
  logic       wd_expired;

`ifdef SEQ_TIMEOUT_EN
  logic wd_count;
  logic wd_clear;

  assign wd_count = run && (state == FETCH_REQ || state == FETCH_WAIT ||
                            state == MEM_REQ   || state == MEM_WAIT);
  assign wd_clear = (state_next != state);

  seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear),
    .count_en (wd_count),
    .expired  (wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_REQ;
    else     state <= state_next;
  end

  // Next-state and error-cause selection.
  always_comb begin
    state_next = state;
    err_next   = err_code;
    case (state)
      FETCH_REQ:  if (run && bus.ifu_req_ready) state_next = FETCH_WAIT;
      FETCH_WAIT: if (bus.ifu_rsp_valid)        state_next = DECODE;
      DECODE: begin
        if (!itype_legal(itype)) begin
          state_next = ERROR;
          err_next   = ERR_ITYPE;
        end else begin
          state_next = EXECUTE;
        end
      end
      EXECUTE:    state_next = (is_load || is_store) ? MEM_REQ : WRITEBACK;
      MEM_REQ:    if (bus.lsu_req_ready) state_next = MEM_WAIT;
      MEM_WAIT:   if (bus.lsu_rsp_valid) state_next = WRITEBACK;
      WRITEBACK:  state_next = FETCH_REQ;
      ERROR:      state_next = ERROR;
      default:    state_next = ERROR;
    endcase
    if (wd_expired) begin
      state_next = ERROR;
      err_next   = (state == FETCH_REQ || state == FETCH_WAIT) ? ERR_IFU_TO : ERR_LSU_TO;
    end
  end

  // Architectural registers: PC, latched instruction, retire count, error cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      inst_r   <= '0;
      retired  <= '0;
      err_code <= ERR_NONE;
      wb_flag  <= 1'b0;
      run      <= 1'b0;
    end else begin
      run      <= 1'b1;
      err_code <= err_next;
      if (state == FETCH_WAIT && state_next == DECODE) inst_r <= bus.ifu_rsp_inst;
      if (state == DECODE) wb_flag <= itype_writes_rd(itype);
      if (state == WRITEBACK) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
      end
    end
  end

  assign bus.ifu_req_valid = run && (state == FETCH_REQ);
  assign bus.ifu_addr      = pc;
  assign bus.lsu_req_valid = (state == MEM_REQ);
  assign exe_en            = (state == EXECUTE);
  assign wb_en             = (state == WRITEBACK) && wb_flag;
  assign seq_err           = (state == ERROR);
  assign dbg_state         = state;

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: directed scenarios plus a random
// instruction stream, judged against a per-instruction latency/effect model.
module tb_inst_sequencer;
  import inst_sequencer_pkg::*;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_sequencer_if bus ();
  logic [TYPE_BUS-1:0] itype;
  logic        is_load, is_store;
  logic [31:0] next_pc, pc, inst_r, retired;
  logic        exe_en, wb_en, seq_err;
  logic [1:0]  err_code;
  seq_state_t  dbg_state;

  inst_sequencer #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk), .rst (rst), .bus (bus),
    .itype (itype), .is_load (is_load), .is_store (is_store),
    .next_pc (next_pc), .pc (pc), .inst_r (inst_r),
    .exe_en (exe_en), .wb_en (wb_en), .retired (retired),
    .seq_err (seq_err), .err_code (err_code), .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] model_pc;
  logic [31:0] model_retired;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_inst  = '0;
    bus.lsu_req_ready = 1'b0;
    bus.lsu_rsp_valid = 1'b0;
  endtask

  // Reset pulse; ends on the first negedge with the fetch request expected up.
  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_inst_r", inst_r, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_seq_err", {31'b0, seq_err}, 32'h0);
    check("rst_err_code", {30'b0, err_code}, 32'h0);
    check("rst_strobes", {28'b0, bus.ifu_req_valid, bus.lsu_req_valid, exe_en, wb_en}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_pc      = RST_PC;
    model_retired = '0;
    @(negedge clk);
    check("first_ifu_req", {31'b0, bus.ifu_req_valid}, 32'h1);
  endtask

  // Runs one instruction from FETCH_REQ to the next FETCH_REQ, acting as
  // IFU, LSU and decoder. ird/irs/lrd/lrs are wait cycles before ready/response.
  task automatic run_inst(input string tag, input logic [31:0] inst,
                          input logic [TYPE_BUS-1:0] it, input logic ld, input logic st,
                          input int ird, input int irs, input int lrd, input int lrs,
                          input logic [31:0] npc);
    int cyc, req_n, wait_n, lreq_n, lwait_n, exe_n, wb_n, exe_at, lreq_hi, exp_lat;
    bit f_acc, f_done, l_acc, l_done, finished, mem;
    cyc = 0; req_n = 0; wait_n = 0; lreq_n = 0; lwait_n = 0;
    exe_n = 0; wb_n = 0; exe_at = -1; lreq_hi = 0;
    f_acc = 0; f_done = 0; l_acc = 0; l_done = 0; finished = 0;
    mem = ld | st;
    exp_lat = 5 + ird + irs + (mem ? 2 + lrd + lrs : 0);
    itype = it; is_load = ld; is_store = st; next_pc = npc;
    while (!finished && cyc < 200) begin
      if (exe_en) begin exe_n++; exe_at = cyc; end
      if (wb_en) wb_n++;
      if (bus.lsu_req_valid) lreq_hi++;
      drive_idle();
      bus.ifu_rsp_inst = $urandom;
      if (bus.ifu_req_valid && f_done) begin
        finished = 1;
      end else begin
        if (bus.ifu_req_valid && !f_acc) begin
          check({tag, "_ifu_addr"}, bus.ifu_addr, model_pc);
          req_n++;
          if (req_n > ird) begin
            bus.ifu_req_ready = 1'b1;
            f_acc = 1;
          end else begin
            bus.ifu_rsp_valid = 1'b1;   // early response must be ignored
            bus.ifu_rsp_inst  = ~inst;
          end
        end else if (f_acc && !f_done) begin
          wait_n++;
          if (wait_n > irs) begin
            bus.ifu_rsp_valid = 1'b1;
            bus.ifu_rsp_inst  = inst;
            f_done = 1;
          end
        end
        if (bus.lsu_req_valid && !l_acc) begin
          lreq_n++;
          if (lreq_n > lrd) begin
            bus.lsu_req_ready = 1'b1;
            l_acc = 1;
          end else begin
            bus.lsu_rsp_valid = 1'b1;   // early response must be ignored
          end
        end else if (l_acc && !l_done) begin
          lwait_n++;
          if (lwait_n > lrs) begin
            bus.lsu_rsp_valid = 1'b1;
            l_done = 1;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_completed"}, {31'b0, finished}, 32'h1);
    model_retired = model_retired + 32'd1;
    model_pc      = npc;
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_exe_pulses"}, exe_n, 1);
    check({tag, "_exe_cycle"}, exe_at, 3 + ird + irs);
    check({tag, "_wb_pulses"}, wb_n, (it == INST_S || it == INST_B) ? 0 : 1);
    check({tag, "_lsu_req_cycles"}, lreq_hi, mem ? lrd + 1 : 0);
    check({tag, "_inst_r"}, inst_r, inst);
    check({tag, "_pc"}, pc, model_pc);
    check({tag, "_retired"}, retired, model_retired);
    check({tag, "_seq_err"}, {31'b0, seq_err}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  logic [TYPE_BUS-1:0] legal_t [6];
  logic [31:0] r, npc;
  logic [TYPE_BUS-1:0] it;
  logic ld, st;
  int hi;

  initial begin
    legal_t = '{INST_R, INST_I, INST_S, INST_B, INST_U, INST_J};
    itype = INST_I; is_load = 0; is_store = 0; next_pc = '0;
    drive_idle();
    #1;
    do_reset();

    // addi x1, x0, 5 with zero-wait IFU
    run_inst("addi", 32'h0050_0093, INST_I, 1'b0, 1'b0, 0, 0, 0, 0, RST_PC + 32'd4);
    check("addi_pc_value", pc, 32'h8000_0004);

    // store with LSU ready on its third request cycle
    run_inst("store", 32'h0011_2023, INST_S, 1'b0, 1'b1, 0, 0, 2, 0, pc + 32'd4);
    // early IFU response during FETCH_REQ
    run_inst("early_rsp", 32'h0000_0533, INST_R, 1'b0, 1'b0, 3, 1, 0, 0, pc + 32'd4);
    // both memory flags set: treated as a memory access
    run_inst("ld_st", 32'h0000_2103, INST_I, 1'b1, 1'b1, 1, 2, 1, 3, pc + 32'd4);

    // random instruction stream
    for (int n = 0; n < 40; n++) begin
      it = legal_t[$urandom_range(0, 5)];
      ld = (it == INST_I) && ($urandom_range(0, 1) == 1);
      st = (it == INST_S);
      if (it == INST_I && $urandom_range(0, 7) == 0) st = 1'b1;
      r = $urandom;
      npc = {r[31:2], 2'b00};
      run_inst("rand", $urandom, it, ld, st,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), npc);
    end

    // illegal itype traps into ERROR
    do_reset();
    itype = ($urandom_range(0, 1) == 1) ? 3'd7 : INST_N;
    is_load = 0; is_store = 0;
    bus.ifu_req_ready = 1'b1;
    @(negedge clk);
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rsp_inst  = 32'hdead_beef;
    @(negedge clk);
    bus.ifu_rsp_valid = 1'b0;
    check("ill_decode_no_err", {31'b0, seq_err}, 32'h0);
    @(negedge clk);
    check("ill_seq_err", {31'b0, seq_err}, 32'h1);
    check("ill_err_code", {30'b0, err_code}, 32'h1);
    check("ill_dbg_state", {31'b0, dbg_state == ERROR}, 32'h1);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      bus.ifu_req_ready = 1'($urandom_range(0, 1));
      bus.lsu_req_ready = 1'($urandom_range(0, 1));
      if (bus.ifu_req_valid || bus.lsu_req_valid || exe_en || wb_en) hi++;
      @(negedge clk);
    end
    check("ill_no_activity", hi, 0);
    check("ill_pc_frozen", pc, RST_PC);
    check("ill_inst_frozen", inst_r, 32'hdead_beef);
    check("ill_still_err", {31'b0, seq_err}, 32'h1);

    // reset pulsed during MEM_WAIT, followed by a stale LSU response
    do_reset();
    itype = INST_I; is_load = 1; is_store = 0; next_pc = RST_PC + 32'd4;
    bus.ifu_req_ready = 1'b1;
    @(negedge clk);
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rsp_inst  = 32'h0000_2083;
    @(negedge clk);
    bus.ifu_rsp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rmw_lsu_req", {31'b0, bus.lsu_req_valid}, 32'h1);
    bus.lsu_req_ready = 1'b1;
    @(negedge clk);
    bus.lsu_req_ready = 1'b0;
    check("rmw_in_wait", {31'b0, bus.lsu_req_valid}, 32'h0);
    rst = 1'b1;
    #1;
    check("rmw_pc", pc, RST_PC);
    check("rmw_strobes", {28'b0, bus.ifu_req_valid, bus.lsu_req_valid, exe_en, wb_en}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.lsu_rsp_valid = 1'b1;
    @(negedge clk);
    bus.lsu_rsp_valid = 1'b0;
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.ifu_req_valid && !bus.lsu_req_valid && !exe_en && !wb_en) hi++;
      @(negedge clk);
    end
    check("rmw_back_in_fetch", hi, 4);
    check("rmw_retired", retired, 32'h0);
    check("rmw_pc_after", pc, RST_PC);

    // IFU never ready
    do_reset();
    hi = 0;
    for (int i = 0; i < 1000; i++) begin
      bus.ifu_req_ready = 1'b0;
      if (bus.ifu_req_valid) hi++;
      @(negedge clk);
    end
`ifdef SEQ_TIMEOUT_EN
    check("to_req_cycles", hi, TO);
    check("to_seq_err", {31'b0, seq_err}, 32'h1);
    check("to_err_code", {30'b0, err_code}, 32'h2);
`else
    check("to_req_cycles", hi, 1000);
    check("to_still_fetching", {31'b0, bus.ifu_req_valid}, 32'h1);
    check("to_no_err", {31'b0, seq_err}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
